// File: rtl/cpu_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, extensions, states, ALU and mux codes.
// The MUL_WAIT state exists only when MULTIPLY_EN is defined.
package cpu_control_pkg;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_ANDI   = 4'b0001;
    localparam logic [3:0] OP_ORI    = 4'b0010;
    localparam logic [3:0] OP_XORI   = 4'b0011;
    localparam logic [3:0] OP_MEMORY = 4'b0100;
    localparam logic [3:0] OP_ADDI   = 4'b0101;
    localparam logic [3:0] OP_SUBI   = 4'b1001;
    localparam logic [3:0] OP_CMPI   = 4'b1011;
    localparam logic [3:0] OP_BCOND  = 4'b1100;
    localparam logic [3:0] OP_MOVI   = 4'b1101;
    localparam logic [3:0] OP_MULI   = 4'b1110;
    localparam logic [3:0] OP_LUI    = 4'b1111;

    // Register-form extensions share codes with their immediate opcodes
    localparam logic [3:0] EXT_AND   = 4'b0001;
    localparam logic [3:0] EXT_OR    = 4'b0010;
    localparam logic [3:0] EXT_XOR   = 4'b0011;
    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_SUB   = 4'b1001;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_MOV   = 4'b1101;
    localparam logic [3:0] EXT_MUL   = 4'b1110;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXECUTE = 4'd3,
        S_LOAD    = 4'd4,
        S_STORE   = 4'd5,
        S_BRANCH  = 4'd6,
        S_JUMP    = 4'd7,
        S_JAL     = 4'd8,
        S_FAULT   = 4'd9
`ifdef MULTIPLY_EN
        ,
        S_MUL_WAIT = 4'd10
`endif
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_CMP = 4'd5;
    localparam logic [3:0] ALU_MOV = 4'd6;
    localparam logic [3:0] ALU_MUL = 4'd7;

    localparam logic [1:0] A_PC       = 2'd0;
    localparam logic [1:0] A_DEST     = 2'd1;
    localparam logic [1:0] B_ONE      = 2'd0;
    localparam logic [1:0] B_SOURCE   = 2'd1;
    localparam logic [1:0] B_IMM_SEXT = 2'd2;
    localparam logic [1:0] B_IMM_ZEXT = 2'd3;

    localparam logic [1:0] WSEL_ALU    = 2'd0;
    localparam logic [1:0] WSEL_MEMORY = 2'd1;
    localparam logic [1:0] WSEL_PC     = 2'd2;
    localparam logic [1:0] WSEL_LUI    = 2'd3;

    typedef struct packed {
        logic       legal;
        logic [3:0] alu_op;
        logic [1:0] b_sel;
        logic [1:0] wsel;
        logic       rwe;
        logic       fwe;
    } exec_ctrl_t;

    // Single-cycle ALU instructions; anything else comes back with legal = 0
    function automatic exec_ctrl_t exec_decode(input logic [3:0] op, input logic [3:0] ext);
        exec_ctrl_t c;
        logic [3:0] code;
        c       = '0;
        c.legal = 1'b1;
        c.rwe   = 1'b1;
        c.wsel  = WSEL_ALU;
        c.b_sel = B_IMM_SEXT;
        code    = op;
        case (op)
            OP_RTYPE: begin
                code    = ext;
                c.b_sel = B_SOURCE;
            end
            OP_ANDI, OP_ORI, OP_XORI:           c.b_sel = B_IMM_ZEXT;
            OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: c.b_sel = B_IMM_SEXT;
            OP_LUI: begin
                code    = EXT_MOV;
                c.b_sel = B_IMM_ZEXT;
                c.wsel  = WSEL_LUI;
            end
            default: code = 4'b0000;
        endcase
        case (code)
            EXT_AND: c.alu_op = ALU_AND;
            EXT_OR:  c.alu_op = ALU_OR;
            EXT_XOR: c.alu_op = ALU_XOR;
            EXT_MOV: c.alu_op = ALU_MOV;
            EXT_ADD: begin
                c.alu_op = ALU_ADD;
                c.fwe    = 1'b1;
            end
            EXT_SUB: begin
                c.alu_op = ALU_SUB;
                c.fwe    = 1'b1;
            end
            EXT_CMP: begin
                c.alu_op = ALU_CMP;
                c.fwe    = 1'b1;
                c.rwe    = 1'b0;
            end
            default: begin
                c.legal = 1'b0;
                c.rwe   = 1'b0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the MAX_WAIT-th one.
module wait_timer #(
    parameter int unsigned MAX_WAIT  = 15,
    parameter int unsigned WAIT_BITS = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);

    logic [WAIT_BITS-1:0] r_count;

    // Consecutive not-ready counter; any ready cycle or leaving the access clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= {WAIT_BITS{1'b0}};
        end else if (!i_active || i_ready) begin
            r_count <= {WAIT_BITS{1'b0}};
        end else begin
            r_count <= r_count + WAIT_BITS'(1);
        end
    end

    // r_count holds the cycles already missed, so the current cycle is number r_count+1
    assign o_timeout = i_active & ~i_ready & (r_count == WAIT_BITS'(MAX_WAIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM driving the 16-bit CPU datapath from instruction register fields.
// Define MULTIPLY_EN to add the MUL_WAIT state for MULI / RTYPE MUL.
module multicycle_controller
    import cpu_control_pkg::*;
#(
    parameter int unsigned ALU_OP_BITS = 4,
    parameter int unsigned MAX_WAIT    = 15,
    parameter int unsigned WAIT_BITS   = 8
`ifdef MULTIPLY_EN
    ,
    parameter int unsigned MUL_LATENCY = 4
`endif
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3:0]             instruction_operation,
    input  logic [3:0]             instruction_extension,
    input  logic                   memory_ready,
    input  logic                   branch_taken,
    output logic                   memory_request,
    output logic                   memory_write_enable,
    output logic                   memory_address_select,
    output logic                   instruction_write_enable,
    output logic                   program_counter_write_enable,
    output logic                   program_counter_select,
    output logic [1:0]             alu_a_select,
    output logic [1:0]             alu_b_select,
    output logic [ALU_OP_BITS-1:0] alu_operation,
    output logic                   register_write_enable,
    output logic [1:0]             register_write_select,
    output logic                   flags_write_enable,
    output logic                   illegal_instruction,
    output logic                   bus_fault
);

    state_t     r_state;
    state_t     w_next;
    logic       r_bus_fault;
    logic       w_mem_active;
    logic       w_timeout;
    logic       w_is_mul;
    exec_ctrl_t w_exec;

    assign w_mem_active = (r_state == S_FETCH) | (r_state == S_LOAD) | (r_state == S_STORE);
    assign w_exec       = exec_decode(instruction_operation, instruction_extension);
    assign w_is_mul     = (instruction_operation == OP_MULI) |
                          ((instruction_operation == OP_RTYPE) & (instruction_extension == EXT_MUL));
    assign bus_fault    = r_bus_fault;

    wait_timer #(
        .MAX_WAIT  (MAX_WAIT),
        .WAIT_BITS (WAIT_BITS)
    ) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .i_active  (w_mem_active),
        .i_ready   (memory_ready),
        .o_timeout (w_timeout)
    );

    // State register and sticky bus fault flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bus_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_timeout) begin
                r_bus_fault <= 1'b1;
            end
        end
    end

`ifdef MULTIPLY_EN
    logic [3:0] r_mul_count;
    logic       w_mul_last;

    assign w_mul_last = (r_mul_count == 4'(MUL_LATENCY - 1));

    // Cycles spent in MUL_WAIT for the current multiply
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mul_count <= 4'd0;
        end else if (r_state == S_MUL_WAIT) begin
            r_mul_count <= r_mul_count + 4'd1;
        end else begin
            r_mul_count <= 4'd0;
        end
    end
`endif

    // Next-state and datapath control decode
    always_comb begin
        w_next                       = r_state;
        memory_request               = 1'b0;
        memory_write_enable          = 1'b0;
        memory_address_select        = 1'b0;
        instruction_write_enable     = 1'b0;
        program_counter_write_enable  = 1'b0;
        program_counter_select       = 1'b0;
        alu_a_select                 = A_PC;
        alu_b_select                 = B_ONE;
        alu_operation                = ALU_OP_BITS'(ALU_ADD);
        register_write_enable        = 1'b0;
        register_write_select        = WSEL_ALU;
        flags_write_enable           = 1'b0;
        illegal_instruction          = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                memory_request = 1'b1;
                if (memory_ready) begin
                    instruction_write_enable    = 1'b1;
                    program_counter_write_enable = 1'b1;
                    w_next                       = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_exec.legal) begin
                    w_next = S_EXECUTE;
                end else if (instruction_operation == OP_MEMORY) begin
                    case (instruction_extension)
                        EXT_LOAD:  w_next = S_LOAD;
                        EXT_STOR:  w_next = S_STORE;
                        EXT_JAL:   w_next = S_JAL;
                        EXT_JCOND: w_next = S_JUMP;
                        default: begin
                            illegal_instruction = 1'b1;
                            w_next              = S_FETCH;
                        end
                    endcase
                end else if (instruction_operation == OP_BCOND) begin
                    w_next = S_BRANCH;
                end else if (w_is_mul) begin
`ifdef MULTIPLY_EN
                    w_next = S_MUL_WAIT;
`else
                    illegal_instruction = 1'b1;
                    w_next              = S_FETCH;
`endif
                end else begin
                    illegal_instruction = 1'b1;
                    w_next              = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_a_select          = A_DEST;
                alu_b_select          = w_exec.b_sel;
                alu_operation         = ALU_OP_BITS'(w_exec.alu_op);
                register_write_select = w_exec.wsel;
                register_write_enable = w_exec.rwe;
                flags_write_enable    = w_exec.fwe;
                w_next                = S_FETCH;
            end
            S_LOAD: begin
                memory_request        = 1'b1;
                memory_address_select = 1'b1;
                register_write_select = WSEL_MEMORY;
                if (memory_ready) begin
                    register_write_enable = 1'b1;
                    w_next                = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_STORE: begin
                memory_request        = 1'b1;
                memory_write_enable   = 1'b1;
                memory_address_select = 1'b1;
                if (memory_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end else begin
                    w_next = S_STORE;
                end
            end
            S_BRANCH: begin
                alu_b_select                 = B_IMM_SEXT;
                program_counter_write_enable = branch_taken;
                w_next                       = S_FETCH;
            end
            S_JUMP: begin
                program_counter_select       = 1'b1;
                program_counter_write_enable = branch_taken;
                w_next                       = S_FETCH;
            end
            S_JAL: begin
                register_write_select        = WSEL_PC;
                register_write_enable        = 1'b1;
                program_counter_select       = 1'b1;
                program_counter_write_enable = 1'b1;
                w_next                       = S_FETCH;
            end
`ifdef MULTIPLY_EN
            S_MUL_WAIT: begin
                alu_a_select  = A_DEST;
                alu_b_select  = (instruction_operation == OP_RTYPE) ? B_SOURCE : B_IMM_SEXT;
                alu_operation = ALU_OP_BITS'(ALU_MUL);
                if (w_mul_last) begin
                    register_write_enable = 1'b1;
                    w_next                = S_FETCH;
                end else begin
                    w_next = S_MUL_WAIT;
                end
            end
`endif
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

endmodule
